etcpu_prog_loader: RTL and testbench

Program loader sitting directly upstream of the CPU environment top. It accepts a byte stream (valid/ready), validates a length header, and packs bytes little-endian into 32-bit words. It drives the instruction-memory write port (`inst_mem_wr_wen/addr/dat`) and holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/etcpu_loader_pkg.sv | 7 +
 rtl/etcpu_byte_packer.sv | 32 +++
 rtl/etcpu_prog_loader.sv | 138 +++++++++++++
 tb/tb_etcpu_prog_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/etcpu_loader_pkg.sv
// etcpu_loader_pkg: shared states, error codes and stream geometry for the program loader
package etcpu_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM} err_code_e;
endpackage

// File: rtl/etcpu_byte_packer.sv
// etcpu_byte_packer: assembles accepted bytes little-endian into words, flagging each completed word
module etcpu_byte_packer
  import etcpu_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_vld,
  input  logic [BYTE_W-1:0]            in_byte,
  output logic                         word_vld,
  output logic [WORD_BYTES*BYTE_W-1:0] word
);
  localparam int W = WORD_BYTES * BYTE_W;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] sr_q, sr_d;
  // Shifting right puts the first byte of a word at bits [7:0] after four bytes.
  always_comb begin
    word     = {in_byte, sr_q[W-1:BYTE_W]};
    word_vld = in_vld && cnt_q == 2'd3;
    cnt_d    = clear ? 2'd0 : in_vld ? cnt_q + 2'd1 : cnt_q;
    sr_d     = in_vld ? word : sr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/etcpu_prog_loader.sv
// etcpu_prog_loader: streams a length-prefixed, XOR-checksummed image into instruction memory
// and releases the CPU from reset only once the image is verified.
module etcpu_prog_loader
  import etcpu_loader_pkg::*;
#(
  parameter int          INST_MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        inst_mem_wr_wen,
  output logic [31:0] inst_mem_wr_addr,
  output logic [31:0] inst_mem_wr_dat,
  output logic        rst_n_cpu,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(INST_MEM_DEPTH + 1);
  state_e      state_q, state_d;
  err_code_e   code_q, code_d;
  logic [CW-1:0] wcnt_q, wcnt_d, n_q, n_d;
  logic [31:0] xor_q, xor_d, addr_q, addr_d, dat_q, dat_d, word;
  logic        wen_q, wen_d, rst_n_cpu_q, rst_n_cpu_d, done_q, done_d, err_q, err_d;
  logic        fire, go, word_vld;

  assign s_ready          = state_q inside {LEN, DATA, CSUM};
  assign busy             = s_ready;
  assign fire             = s_valid && s_ready;
  assign go               = start && state_q inside {IDLE, DONE, ERR};
  assign inst_mem_wr_wen  = wen_q;
  assign inst_mem_wr_addr = addr_q;
  assign inst_mem_wr_dat  = dat_q;
  assign rst_n_cpu        = rst_n_cpu_q;
  assign done             = done_q;
  assign err              = err_q;
  assign err_code         = code_q;

  etcpu_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (go),
    .in_vld   (fire),
    .in_byte  (s_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    n_d         = n_q;
    xor_d       = xor_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    wen_d       = 1'b0;
    rst_n_cpu_d = rst_n_cpu_q;
    done_d      = done_q;
    err_d       = err_q;
    code_d      = code_q;
    if (go) begin
      state_d     = LEN;
      wcnt_d      = '0;
      xor_d       = '0;
      rst_n_cpu_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      code_d      = ERR_NONE;
    end
    if (word_vld) begin
      case (state_q)
        LEN: begin
          if (word == 32'd0 || word > 32'(INST_MEM_DEPTH)) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            state_d = DATA;
            n_d     = word[CW-1:0];
          end
        end
        DATA: begin
          wen_d   = 1'b1;
          addr_d  = BASE_ADDR + (32'(wcnt_q) << 2);
          dat_d   = word;
          xor_d   = xor_q ^ word;
          wcnt_d  = wcnt_q + CW'(1);
          state_d = wcnt_d == n_q ? CSUM : DATA;
        end
        CSUM: begin
          if (word == xor_q) begin
            state_d     = DONE;
            done_d      = 1'b1;
            rst_n_cpu_d = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      n_q         <= '0;
      xor_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      wen_q       <= 1'b0;
      rst_n_cpu_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      n_q         <= n_d;
      xor_q       <= xor_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      wen_q       <= wen_d;
      rst_n_cpu_q <= rst_n_cpu_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end
endmodule

// File: tb/tb_etcpu_prog_loader.sv
// tb_etcpu_prog_loader: randomized image loads checked against a write scoreboard and a status model
module tb_etcpu_prog_loader;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 0, rst = 1, start = 0, s_valid = 0;
  logic [7:0]  s_data = 0;
  logic        s_ready, wen, rst_n_cpu, busy, done, err;
  logic [31:0] addr, dat;
  logic [1:0]  err_code;

  int n_chk = 0, n_fail = 0, n_wr = 0;
  logic [31:0] last_addr = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  etcpu_prog_loader #(.INST_MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .inst_mem_wr_wen(wen), .inst_mem_wr_addr(addr),
    .inst_mem_wr_dat(dat), .rst_n_cpu(rst_n_cpu), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Write monitor: every write pulse must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (!rst && wen) begin
      n_wr++;
      last_addr = addr;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got addr %h dat %h expected no write", addr, dat);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", addr, e[63:32]);
        chk("wr_dat", dat, e[31:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    int w = 0;
    s_valid = 1;
    s_data  = b;
    while (!s_ready) begin
      if (w++ > 50) begin
        $display("FAIL s_ready_wait: got 0 expected 1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_s_ready", 32'(s_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_rst_n_cpu", 32'(rst_n_cpu), 0);
    chk("start_done_err", {30'd0, done, err}, 0);
  endtask

  function automatic void push4(inout logic [7:0] q[$], input logic [31:0] w);
    for (int k = 0; k < 4; k++) q.push_back(8'(w >> (8 * k)));
  endfunction

  // Full load of img with header nhdr and checksum word csum; status is checked one cycle after the last byte.
  task automatic run_load(input logic [31:0] nhdr, input logic [31:0] csum, input int gap, input int start_at);
    logic [7:0]  bq[$];
    logic [31:0] x = 0;
    bit bad = (nhdr == 0 || nhdr > DEPTH);
    int wr0 = n_wr;
    push4(bq, nhdr);
    if (!bad) begin
      for (int i = 0; i < int'(nhdr); i++) begin
        exp_q.push_back({BASE + 32'(4 * i), img[i]});
        x ^= img[i];
        push4(bq, img[i]);
      end
      push4(bq, csum);
    end
    pulse_start();
    for (int i = 0; i < bq.size(); i++) begin
      while ($urandom_range(99) < gap) begin @(posedge clk); #1; end
      if (i == start_at) start = 1;
      send(bq[i]);
      start = 0;
    end
    chk("end_s_ready", 32'(s_ready), 0);
    chk("end_busy", 32'(busy), 0);
    if (bad) begin
      chk("len_err", 32'(err), 1);
      chk("len_code", 32'(err_code), 1);
      chk("len_rst_n_cpu", 32'(rst_n_cpu), 0);
      chk("len_writes", 32'(n_wr - wr0), 0);
    end else if (csum == x) begin
      chk("done", 32'(done), 1);
      chk("done_err", 32'(err), 0);
      chk("done_rst_n_cpu", 32'(rst_n_cpu), 1);
      chk("writes", 32'(n_wr - wr0), nhdr);
    end else begin
      chk("csum_err", 32'(err), 1);
      chk("csum_code", 32'(err_code), 2);
      chk("csum_done", 32'(done), 0);
      chk("csum_rst_n_cpu", 32'(rst_n_cpu), 0);
      chk("writes", 32'(n_wr - wr0), nhdr);
    end
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wen"}, 32'(wen), 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_dat"}, dat, 0);
    chk({tag, "_status"}, {27'd0, rst_n_cpu, done, err, err_code}, 0);
  endtask

  initial begin
    logic [31:0] x;
    logic [7:0]  bq[$];
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 0;
    @(posedge clk); #1;

    img = '{32'h00000013, 32'hDEADBEEF};
    run_load(2, 32'hDEADBEFC, 0, -1);
    run_load(2, 32'h00000000, 0, -1);
    run_load(2, 32'hDEADBEFC, 0, -1);

    run_load(0, 0, 0, -1);
    run_load(DEPTH + 1, 0, 10, -1);

    img.delete();
    x = 0;
    for (int i = 0; i < DEPTH; i++) begin
      img.push_back($urandom);
      x ^= img[i];
    end
    run_load(DEPTH, x, 30, -1);
    chk("full_last_addr", last_addr, BASE + 32'(4 * (DEPTH - 1)));

    img.delete();
    x = 0;
    for (int i = 0; i < 8; i++) begin
      img.push_back($urandom);
      x ^= img[i];
    end
    run_load(8, x, 20, 10);

    // Abort mid-DATA: one word is written, then reset lands between bytes.
    pulse_start();
    push4(bq, 4);
    for (int i = 0; i < 6; i++) push4(bq, img[i / 4]);
    exp_q.push_back({BASE, img[0]});
    for (int i = 0; i < 9; i++) send(bq[i]);
    @(posedge clk); #1;
    rst = 1;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_idle_s_ready", 32'(s_ready), 0);
    run_load(8, x, 10, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
